// File: rtl/frame_ram_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : frame_ram_scheduler_if
// Brief    : Capture/read client and single-port RAM bus of the frame scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface frame_ram_scheduler_if #(
    parameter int AW = 15,
    parameter int DW = 8
);
    logic          frame_start;
    logic          wr_req;
    logic [DW-1:0] wr_data;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          proc_done;
    logic          rd_grant;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_wren;
    logic [DW-1:0] ram_q;
    logic [1:0]    state;
    logic          frame_ready;
    logic [7:0]    skip_cnt;
    logic [7:0]    abort_cnt;

    modport master (
        output frame_start, wr_req, wr_data, rd_req, rd_addr, proc_done, ram_q,
        input  rd_grant, rd_valid, rd_data, ram_addr, ram_wdata, ram_wren,
               state, frame_ready, skip_cnt, abort_cnt
    );

    modport slave (
        input  frame_start, wr_req, wr_data, rd_req, rd_addr, proc_done, ram_q,
        output rd_grant, rd_valid, rd_data, ram_addr, ram_wdata, ram_wren,
               state, frame_ready, skip_cnt, abort_cnt
    );
endinterface
`default_nettype wire

// File: rtl/frame_ram_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : frame_ram_scheduler
// Brief    : Single-port frame RAM scheduler; capture writes win, reads fill gaps.
// Revision : 1.0 - initial release
// ============================================================================
module frame_ram_scheduler #(
    parameter int DEPTH = 19200,
    parameter int AW    = 15,
    parameter int DW    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    frame_ram_scheduler_if.slave bus
);

    localparam logic [1:0]    S_IDLE      = 2'b00;
    localparam logic [1:0]    S_CAPTURE   = 2'b01;
    localparam logic [1:0]    S_PROCESS   = 2'b10;
    localparam logic [AW-1:0] C_LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW-1:0] C_ONE       = AW'(1);
    localparam logic [7:0]    C_CNT_MAX   = 8'hFF;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] w_wr_ptr_nxt;
    logic [AW-1:0] w_wr_addr;
    logic [7:0]    r_skip_cnt;
    logic [7:0]    w_skip_cnt_nxt;
    logic [7:0]    r_abort_cnt;
    logic [7:0]    w_abort_cnt_nxt;
    logic          w_wr_fire;
    logic          w_rd_fire;
    logic [AW-1:0] r_ram_addr;
    logic [DW-1:0] r_ram_wdata;
    logic          r_ram_wren;
    logic          r_rd_pend;
    logic          r_rd_valid;

    assign w_wr_fire = (r_state == S_CAPTURE) & bus.wr_req;
    // Grant is combinational so a held request is accepted in the same cycle.
    assign w_rd_fire = rst_n & bus.rd_req & ~w_wr_fire;
    assign w_wr_addr = bus.frame_start ? '0 : r_wr_ptr;

    always_comb begin
        w_state_nxt     = r_state;
        w_wr_ptr_nxt    = r_wr_ptr;
        w_skip_cnt_nxt  = r_skip_cnt;
        w_abort_cnt_nxt = r_abort_cnt;
        case (r_state)
            S_IDLE: begin
                if (bus.frame_start) begin
                    w_state_nxt  = S_CAPTURE;
                    w_wr_ptr_nxt = '0;
                end
            end
            S_CAPTURE: begin
                if (bus.frame_start) begin
                    // A pixel arriving with frame_start is pixel 0 of the new frame.
                    w_wr_ptr_nxt = w_wr_fire ? C_ONE : '0;
                    if (r_abort_cnt != C_CNT_MAX) begin
                        w_abort_cnt_nxt = r_abort_cnt + 8'd1;
                    end
                end else if (w_wr_fire) begin
                    if (r_wr_ptr == C_LAST_ADDR) begin
                        w_state_nxt  = S_PROCESS;
                        w_wr_ptr_nxt = '0;
                    end else begin
                        w_wr_ptr_nxt = r_wr_ptr + C_ONE;
                    end
                end
            end
            S_PROCESS: begin
                if (bus.proc_done) begin
                    w_state_nxt  = bus.frame_start ? S_CAPTURE : S_IDLE;
                    w_wr_ptr_nxt = '0;
                end else if (bus.frame_start && (r_skip_cnt != C_CNT_MAX)) begin
                    w_skip_cnt_nxt = r_skip_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_wr_ptr_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_skip_cnt  <= '0;
            r_abort_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_wr_ptr    <= w_wr_ptr_nxt;
            r_skip_cnt  <= w_skip_cnt_nxt;
            r_abort_cnt <= w_abort_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_ram_wren  <= 1'b0;
            r_rd_pend   <= 1'b0;
            r_rd_valid  <= 1'b0;
        end else begin
            r_ram_wren <= w_wr_fire;
            if (w_wr_fire) begin
                r_ram_addr  <= w_wr_addr;
                r_ram_wdata <= bus.wr_data;
            end else if (w_rd_fire) begin
                r_ram_addr <= bus.rd_addr;
            end
            // RAM returns data one cycle after the address, so valid trails grant by two.
            r_rd_pend  <= w_rd_fire;
            r_rd_valid <= r_rd_pend;
        end
    end

    assign bus.rd_grant    = w_rd_fire;
    assign bus.rd_valid    = r_rd_valid;
    assign bus.rd_data     = r_rd_valid ? bus.ram_q : '0;
    assign bus.ram_addr    = r_ram_addr;
    assign bus.ram_wdata   = r_ram_wdata;
    assign bus.ram_wren    = r_ram_wren;
    assign bus.state       = r_state;
    assign bus.frame_ready = (r_state == S_PROCESS);
    assign bus.skip_cnt    = r_skip_cnt;
    assign bus.abort_cnt   = r_abort_cnt;

endmodule
`default_nettype wire

// File: tb/tb_frame_ram_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_ram_scheduler
// Brief    : Randomized bench for frame_ram_scheduler against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_ram_scheduler;

    localparam int C_DEPTH = 19200;
    localparam int C_AW    = 15;
    localparam int C_DW    = 8;
    localparam int C_WORDS = 1 << C_AW;

    typedef struct {
        int         due;
        logic [7:0] data;
    } rd_t;

    logic clk;
    logic rst_n;

    frame_ram_scheduler_if #(.AW(C_AW), .DW(C_DW)) bus ();

    frame_ram_scheduler #(
        .DEPTH (C_DEPTH),
        .AW    (C_AW),
        .DW    (C_DW)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] mem    [C_WORDS];
    logic [7:0] shadow [C_WORDS];

    always @(posedge clk) begin
        if (bus.ram_wren) mem[bus.ram_addr] <= bus.ram_wdata;
        bus.ram_q <= mem[bus.ram_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          mode    = 0;   // 0 idle, 1 capture, 2 process
    int          ptr     = 0;
    int          skip_n  = 0;
    int          abort_n = 0;
    logic        exp_wren;
    logic [14:0] exp_addr;
    logic [7:0]  exp_wdata;
    rd_t         rdq [$];
    logic        pend;
    logic [14:0] pend_addr;
    logic        last_grant;

    function automatic logic [7:0] pat(input int a);
        return 8'((a * 37 + 11) & 255);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        mode      = 0;
        ptr       = 0;
        skip_n    = 0;
        abort_n   = 0;
        exp_wren  = 1'b0;
        exp_addr  = '0;
        exp_wdata = '0;
        pend      = 1'b0;
        rdq.delete();
    endtask

    task automatic drive_idle();
        bus.frame_start = 1'b0;
        bus.wr_req      = 1'b0;
        bus.wr_data     = '0;
        bus.rd_req      = 1'b0;
        bus.rd_addr     = '0;
        bus.proc_done   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.rd_req  = 1'b1;
        bus.rd_addr = 15'd7;
        rst_n = 1'b0;
        #1;
        check_val("rst_state",     bus.state,       0);
        check_val("rst_ram_addr",  bus.ram_addr,    0);
        check_val("rst_ram_wdata", bus.ram_wdata,   0);
        check_val("rst_ram_wren",  bus.ram_wren,    0);
        check_val("rst_rd_grant",  bus.rd_grant,    0);
        check_val("rst_rd_valid",  bus.rd_valid,    0);
        check_val("rst_rd_data",   bus.rd_data,     0);
        check_val("rst_frm_ready", bus.frame_ready, 0);
        check_val("rst_skip",      bus.skip_cnt,    0);
        check_val("rst_abort",     bus.abort_cnt,   0);
        drive_idle();
        repeat (3) @(negedge clk);
        check_val("rst_hold_valid", bus.rd_valid, 0);
        rst_n = 1'b1;
        model_reset();
    endtask

    // One clock of stimulus: check registered outputs, drive inputs, check grant, advance model.
    task automatic step(input logic fs, input logic wr, input logic [7:0] wd,
                        input logic rr, input logic [14:0] ra, input logic pd);
        logic g;
        logic exp_v;
        int   m0;
        rd_t  e;
        @(negedge clk);
        check_val("state",       bus.state,       mode);
        check_val("frame_ready", bus.frame_ready, (mode == 2));
        check_val("skip_cnt",    bus.skip_cnt,    skip_n);
        check_val("abort_cnt",   bus.abort_cnt,   abort_n);
        check_val("ram_wren",    bus.ram_wren,    exp_wren);
        check_val("ram_addr",    bus.ram_addr,    exp_addr);
        if (exp_wren) check_val("ram_wdata", bus.ram_wdata, exp_wdata);
        exp_v = (rdq.size() > 0) && (rdq[0].due == cyc);
        check_val("rd_valid", bus.rd_valid, exp_v);
        if (exp_v) begin
            check_val("rd_data", bus.rd_data, rdq[0].data);
            e = rdq.pop_front();
        end

        bus.frame_start = fs;
        bus.wr_req      = wr;
        bus.wr_data     = wd;
        bus.rd_req      = rr;
        bus.rd_addr     = ra;
        bus.proc_done   = pd;
        #1;
        g = rr && !((mode == 1) && wr);
        check_val("rd_grant", bus.rd_grant, g);
        last_grant = g;

        m0       = mode;
        exp_wren = 1'b0;
        if ((m0 == 1) && wr) begin
            shadow[ptr] = wd;
            exp_wren    = 1'b1;
            exp_addr    = 15'(ptr);
            exp_wdata   = wd;
            if (ptr == C_DEPTH - 1) begin
                mode = 2;
                ptr  = 0;
            end else begin
                ptr++;
            end
        end else if (g) begin
            exp_addr = ra;
            e.due    = cyc + 2;
            e.data   = shadow[ra];
            rdq.push_back(e);
        end

        if ((m0 == 0) && fs) begin
            mode = 1;
            ptr  = 0;
        end else if ((m0 == 1) && fs) begin
            ptr = 0;
            if (abort_n < 255) abort_n++;
        end else if (m0 == 2) begin
            if (pd) begin
                mode = fs ? 1 : 0;
                ptr  = 0;
            end else if (fs && (skip_n < 255)) begin
                skip_n++;
            end
        end
        cyc++;
    endtask

    // Client that holds each random request until it is granted.
    task automatic rand_step(input logic fs, input logic wr, input logic [7:0] wd,
                             input logic pd, input int rd_pct);
        if (!pend && ($urandom_range(99) < rd_pct)) begin
            pend      = 1'b1;
            pend_addr = 15'($urandom);
        end
        step(fs, wr, wd, pend, pend_addr, pd);
        if (last_grant) pend = 1'b0;
    endtask

    task automatic run_capture(input int wr_pct, input logic addr_data, input logic do_collide);
        int   guard;
        logic wr;
        logic collided;
        guard    = 0;
        collided = 1'b0;
        while ((mode == 1) && (guard < 40000)) begin
            if (do_collide && !collided && (ptr == 1000)) begin
                pend = 1'b0;
                step(1'b0, 1'b1, 8'(ptr), 1'b1, 15'd5, 1'b0);
                step(1'b0, 1'b0, 8'h00, 1'b1, 15'd5, 1'b0);
                collided = 1'b1;
            end else begin
                wr = ($urandom_range(99) < wr_pct);
                rand_step(1'b0, wr, addr_data ? 8'(ptr) : 8'($urandom), 1'b0, 30);
            end
            guard++;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        n_fail++;
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < C_WORDS; i++) begin
            mem[i]    = pat(i);
            shadow[i] = pat(i);
        end
        rst_n = 1'b0;
        drive_idle();
        model_reset();
        do_reset();

        // Idle: reads granted, stray writes ignored.
        repeat (60) rand_step(1'b0, 1'($urandom_range(1)), 8'($urandom), 1'b0, 50);
        rand_step(1'b1, 1'b0, 8'h00, 1'b0, 0);
        run_capture(90, 1'b1, 1'b1);

        // Process: three back-to-back reads, then random reads with two skipped frames.
        pend = 1'b0;
        for (int a = 0; a < 3; a++) step(1'b0, 1'b0, 8'h00, 1'b1, 15'(a), 1'b0);
        for (int i = 0; i < 200; i++)
            rand_step((i == 50) || (i == 120), 1'($urandom_range(1)), 8'($urandom), 1'b0, 80);
        rand_step(1'b0, 1'b0, 8'h00, 1'b1, 30);
        repeat (20) rand_step(1'b0, 1'b0, 8'h00, 1'b0, 50);

        // Abort after 100 writes, then complete the frame.
        rand_step(1'b1, 1'b0, 8'h00, 1'b0, 0);
        repeat (100) rand_step(1'b0, 1'b1, 8'($urandom), 1'b0, 30);
        rand_step(1'b1, 1'b0, 8'h00, 1'b0, 0);
        run_capture(97, 1'b0, 1'b0);

        // proc_done with frame_start restarts capture directly.
        repeat (30) rand_step(1'b0, 1'b0, 8'h00, 1'b0, 60);
        rand_step(1'b1, 1'b0, 8'h00, 1'b1, 0);
        run_capture(97, 1'b0, 1'b0);

        // Saturate the skip counter.
        repeat (300) rand_step(1'b1, 1'b0, 8'h00, 1'b0, 40);
        repeat (5) rand_step(1'b0, 1'b0, 8'h00, 1'b0, 0);

        // Reset the cycle after a grant: the in-flight read must vanish.
        pend = 1'b0;
        step(1'b0, 1'b0, 8'h00, 1'b1, 15'd123, 1'b0);
        do_reset();
        repeat (5) rand_step(1'b0, 1'b0, 8'h00, 1'b0, 0);
        rand_step(1'b1, 1'b0, 8'h00, 1'b0, 0);
        repeat (20) rand_step(1'b0, 1'($urandom_range(1)), 8'($urandom), 1'b0, 30);
        repeat (4) rand_step(1'b0, 1'b0, 8'h00, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
